// File: rtl/cpu_ctrl.sv
// cpu_ctrl: fetch/load/read/execute/writeback sequencer for the 8-bit basic computer.
// Optional single-step mode (step_mode/step ports, SWAIT state) under CPU_CTRL_SINGLE_STEP_EN.
module cpu_ctrl #(
  parameter int PC_W     = 4,
  parameter int END_ADDR = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pause,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic            step_mode,
  input  logic            step,
`endif
  output logic [PC_W-1:0] pc,
  input  logic [7:0]      inst,
  output logic [7:0]      ir,
  input  logic [1:0]      op,
  input  logic [1:0]      rd,
  input  logic [1:0]      rs,
  input  logic [1:0]      rt,
  output logic [1:0]      alu_op,
  output logic [1:0]      rf_ra1,
  output logic [1:0]      rf_ra2,
  output logic [1:0]      rf_wa,
  output logic            opnd_le,
  output logic            alu_le,
  output logic            rf_we,
  output logic            busy,
  output logic            done
);
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, READ, EXEC, WB, DONE
`ifdef CPU_CTRL_SINGLE_STEP_EN
    , SWAIT
`endif
  } state_t;
  localparam logic [PC_W-1:0] LAST = PC_W'(END_ADDR);
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        state_d = start ? FETCH : IDLE;
        pc_d    = start ? '0 : pc_q;
      end
      FETCH: state_d = pause ? FETCH : LOAD;
      LOAD: begin
        ir_d    = inst;
        state_d = READ;
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        pc_d = (pc_q == LAST) ? pc_q : pc_q + 1'b1;
`ifdef CPU_CTRL_SINGLE_STEP_EN
        state_d = (pc_q == LAST) ? DONE : (step_mode ? SWAIT : FETCH);
`else
        state_d = (pc_q == LAST) ? DONE : FETCH;
`endif
      end
      DONE: state_d = IDLE;
`ifdef CPU_CTRL_SINGLE_STEP_EN
      SWAIT: state_d = step ? FETCH : SWAIT;
`endif
      default: state_d = IDLE;
    endcase
  end
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign alu_op  = op;
  assign rf_ra1  = rs;
  assign rf_ra2  = rt;
  assign rf_wa   = rd;
  assign opnd_le = state_q == READ;
  assign alu_le  = state_q == EXEC;
  assign rf_we   = state_q == WB;
  assign done    = state_q == DONE;
  assign busy    = !(state_q == IDLE || state_q == DONE);
endmodule
